// File: rtl/fifo_dot_mac_if.sv
// ---------------------------------------------------------------------------
// fifo_dot_mac_if
// Bundles the control, operand-FIFO and result signals of fifo_dot_mac.
//   start          : begin a new dot product
//   a_data/b_data  : registered read data of the A/B operand FIFOs
//   a_empty/b_empty: FIFO empty flags
//   a_rden/b_rden  : FIFO read enables (driven by the MAC)
//   result         : accumulated dot product, valid while done=1
//   done           : level, held until the next start
//   busy           : high while the MAC is running
// slave  : the MAC's view (fifo_dot_mac)
// master : the environment's view (FIFOs + controller)
// ---------------------------------------------------------------------------
interface fifo_dot_mac_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
);
    logic                  start;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_empty;
    logic                  a_rden;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_empty;
    logic                  b_rden;
    logic [ACC_WIDTH-1:0]  result;
    logic                  done;
    logic                  busy;

    modport slave (
        input  start, a_data, a_empty, b_data, b_empty,
        output a_rden, b_rden, result, done, busy
    );

    modport master (
        output start, a_data, a_empty, b_data, b_empty,
        input  a_rden, b_rden, result, done, busy
    );
endinterface

// File: rtl/fifo_dot_mac.sv
// ---------------------------------------------------------------------------
// fifo_dot_mac
// Pops operand pairs in lockstep from two registered-output FIFOs and
// accumulates LEN unsigned products into a dot product (wrapping modulo
// 2^ACC_WIDTH). done/result are registered and held until the next start.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fifo_dot_mac_if.slave (start, FIFO data/empty/rden, result,
//           done, busy)
// ---------------------------------------------------------------------------
module fifo_dot_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN        = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_dot_mac_if.slave bus
);
    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       issued_q, issued_d;
    logic [CNT_W-1:0]       consumed_q, consumed_d;
    logic                   vld_p1_q, vld_p1_d;
    logic [ACC_WIDTH-1:0]   result_q, result_d;
    logic                   done_q, done_d;
    logic                   rd;

    // Unsigned full-width product, added with natural wrap-around.
    function automatic logic [ACC_WIDTH-1:0] mac_wrap(
        input logic [ACC_WIDTH-1:0]  acc,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] prod;
        prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        return acc + ACC_WIDTH'(prod);
    endfunction

    // Both FIFOs are popped together or not at all, so pairs never skew.
    assign rd = (state_q == RUN) && !bus.a_empty && !bus.b_empty &&
                (issued_q < LEN_C);

    assign bus.a_rden = rd;
    assign bus.b_rden = rd;
    assign bus.busy   = (state_q == RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        issued_d   = issued_q;
        consumed_d = consumed_q;
        vld_p1_d   = 1'b0;
        result_d   = result_q;
        done_d     = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    acc_d      = '0;
                    issued_d   = '0;
                    consumed_d = '0;
                    done_d     = 1'b0;
                end
            end
            RUN: begin
                // Stage p0 -> p1: read issued this cycle, data arrives next.
                if (rd) begin
                    issued_d = issued_q + CNT_W'(1);
                end
                vld_p1_d = rd;
                // Stage p1: FIFO outputs hold the popped pair; accumulate.
                if (vld_p1_q) begin
                    acc_d      = mac_wrap(acc_q, bus.a_data, bus.b_data);
                    consumed_d = consumed_q + CNT_W'(1);
                    if (consumed_d == LEN_C) begin
                        state_d  = DONE;
                        result_d = acc_d;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            issued_q   <= '0;
            consumed_q <= '0;
            vld_p1_q   <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            issued_q   <= issued_d;
            consumed_q <= consumed_d;
            vld_p1_q   <= vld_p1_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_fifo_dot_mac.sv
// ---------------------------------------------------------------------------
// tb_fifo_dot_mac
// Drives two fifo_dot_mac instances (ACC_WIDTH 24 and 16) in lockstep from
// one pair of modelled registered-output FIFOs; expected results are the
// plain sum of the first LEN pushed products, truncated to each width.
// ---------------------------------------------------------------------------
module tb_fifo_dot_mac;
    localparam int DW  = 8;
    localparam int LEN = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_dot_mac_if #(.DATA_WIDTH(DW), .ACC_WIDTH(24)) bus8 ();
    fifo_dot_mac_if #(.DATA_WIDTH(DW), .ACC_WIDTH(16)) bus16 ();

    fifo_dot_mac #(.DATA_WIDTH(DW), .LEN(LEN), .ACC_WIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );
    fifo_dot_mac #(.DATA_WIDTH(DW), .LEN(LEN), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16)
    );

    // ---------------- FIFO model ----------------
    logic [DW-1:0] amem [0:1023];
    logic [DW-1:0] bmem [0:1023];
    int            a_wp = 0, b_wp = 0;
    int            a_rp = 0, b_rp = 0;
    int            b_pops = 0;
    int            stall_cnt = 0;
    logic [DW-1:0] a_dout = '0, b_dout = '0;
    logic          flush = 1'b0, stall_arm = 1'b0, rnd_en = 1'b0;
    logic          a_rstall = 1'b0, b_rstall = 1'b0;
    int            proto_err = 0;
    logic          start;

    logic [DW-1:0] ref_a[$];
    logic [DW-1:0] ref_b[$];

    int vectors = 0;
    int miscompares = 0;

    assign bus8.start   = start;
    assign bus8.a_data  = a_dout;
    assign bus8.b_data  = b_dout;
    assign bus8.a_empty = (a_rp == a_wp) || a_rstall;
    assign bus8.b_empty = (b_rp == b_wp) || b_rstall || (stall_cnt != 0);
    assign bus16.start   = start;
    assign bus16.a_data  = bus8.a_data;
    assign bus16.b_data  = bus8.b_data;
    assign bus16.a_empty = bus8.a_empty;
    assign bus16.b_empty = bus8.b_empty;

    always @(posedge clk) begin
        if (flush) begin
            a_rp      <= a_wp;
            b_rp      <= b_wp;
            b_pops    <= 0;
            stall_cnt <= 0;
        end else begin
            if (bus8.a_rden) begin
                a_dout <= amem[a_rp % 1024];
                a_rp   <= a_rp + 1;
            end
            if (bus8.b_rden) begin
                b_dout <= bmem[b_rp % 1024];
                b_rp   <= b_rp + 1;
                b_pops <= b_pops + 1;
            end
            if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
            else if (stall_arm && bus8.b_rden && b_pops == 3) stall_cnt <= 3;
        end
        a_rstall <= rnd_en && ($urandom_range(3) == 0);
        b_rstall <= rnd_en && ($urandom_range(3) == 0);
        if (rst_n && ((bus8.a_rden !== bus8.b_rden) ||
                      (bus8.a_rden && bus8.a_empty) ||
                      (bus8.b_rden && bus8.b_empty) ||
                      (bus16.a_rden !== bus8.a_rden)))
            proto_err <= proto_err + 1;
    end

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        ref_a.delete();
        ref_b.delete();
    endtask

    task automatic push_a(input logic [DW-1:0] v);
        amem[a_wp % 1024] = v;
        a_wp = a_wp + 1;
        ref_a.push_back(v);
    endtask

    task automatic push_b(input logic [DW-1:0] v);
        bmem[b_wp % 1024] = v;
        b_wp = b_wp + 1;
        ref_b.push_back(v);
    endtask

    // Reference: plain dot product of the first LEN queued pairs.
    function automatic longint model_sum();
        longint s = 0;
        for (int i = 0; i < LEN; i++) s += longint'(ref_a[i]) * longint'(ref_b[i]);
        return s;
    endfunction

    // Pulses start; n = edges after the start edge until done is seen.
    task automatic run_dot(input int pulse_at, output int n, output int rd_cnt,
                           output logic contig, output logic done_after_start);
        int first = -1, last = -1;
        n = 0; rd_cnt = 0; done_after_start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (n <= 200) begin
            @(negedge clk);
            if (n == 0) done_after_start = bus8.done;
            if (bus8.done) break;
            if (bus8.a_rden) begin
                rd_cnt++;
                if (first < 0) first = n;
                last = n;
            end
            start = (n == pulse_at);
            @(posedge clk);
            n++;
        end
        start = 1'b0;
        contig = (rd_cnt > 0) && (last - first + 1 == rd_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        push_a(8'd5); push_b(8'd6);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus8.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", bus8.done); end
        vectors++; if (bus8.result !== 24'd0) begin miscompares++; $display("FAIL reset_result: got %0d want 0", bus8.result); end
        vectors++; if (bus16.result !== 16'd0) begin miscompares++; $display("FAIL reset_result16: got %0d want 0", bus16.result); end
        vectors++; if (bus8.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", bus8.busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if ({bus8.a_rden, bus8.b_rden} !== 2'b00) begin miscompares++; $display("FAIL idle_rden: got %b want 00", {bus8.a_rden, bus8.b_rden}); end
        vectors++; if (a_rp != 0) begin miscompares++; $display("FAIL idle_pops: got %0d want 0", a_rp); end
    endtask

    task automatic test_basic();
        int n, rc; logic ct, das; longint s; int e0;
        do_flush();
        for (int i = 1; i <= LEN; i++) begin push_a(8'(i)); push_b(8'd2); end
        s = model_sum(); e0 = proto_err;
        run_dot(-1, n, rc, ct, das);
        vectors++; if (n != LEN + 1) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", n, LEN + 1); end
        vectors++; if (rc != LEN || ct !== 1'b1) begin miscompares++; $display("FAIL basic_reads: got %0d contig %0b want %0d contig 1", rc, ct, LEN); end
        vectors++; if (bus8.result !== 24'(s)) begin miscompares++; $display("FAIL basic_result: got %0d want %0d", bus8.result, 24'(s)); end
        vectors++; if (bus16.result !== 16'(s)) begin miscompares++; $display("FAIL basic_result16: got %0d want %0d", bus16.result, 16'(s)); end
        vectors++; if (bus8.a_empty !== 1'b1 || bus8.b_empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty: got %0b%0b want 11", bus8.a_empty, bus8.b_empty); end
        vectors++; if (bus8.busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy: got %0b want 0", bus8.busy); end
        vectors++; if (proto_err != e0) begin miscompares++; $display("FAIL basic_protocol: got %0d violations want 0", proto_err - e0); end
    endtask

    task automatic test_wrap();
        int n, rc; logic ct, das; longint s;
        do_flush();
        for (int i = 0; i < LEN; i++) begin push_a(8'd255); push_b(8'd255); end
        s = model_sum();
        run_dot(-1, n, rc, ct, das);
        vectors++; if (bus8.result !== 24'(s)) begin miscompares++; $display("FAIL wrap_result24: got %0d want %0d", bus8.result, 24'(s)); end
        vectors++; if (bus16.result !== 16'(s)) begin miscompares++; $display("FAIL wrap_result16: got %0d want %0d", bus16.result, 16'(s)); end
        vectors++; if (n != LEN + 1) begin miscompares++; $display("FAIL wrap_latency: got %0d want %0d", n, LEN + 1); end
    endtask

    task automatic test_stall();
        int n, rc; logic ct, das; longint s; int e0;
        do_flush();
        for (int i = 1; i <= LEN; i++) begin push_a(8'(i)); push_b(8'd2); end
        s = model_sum(); e0 = proto_err;
        stall_arm = 1'b1;
        run_dot(-1, n, rc, ct, das);
        stall_arm = 1'b0;
        vectors++; if (n != LEN + 1 + 3) begin miscompares++; $display("FAIL stall_latency: got %0d want %0d", n, LEN + 4); end
        vectors++; if (rc != LEN || ct !== 1'b0) begin miscompares++; $display("FAIL stall_reads: got %0d contig %0b want %0d with gap", rc, ct, LEN); end
        vectors++; if (bus8.result !== 24'(s)) begin miscompares++; $display("FAIL stall_result: got %0d want %0d", bus8.result, 24'(s)); end
        vectors++; if (proto_err != e0) begin miscompares++; $display("FAIL stall_protocol: got %0d violations want 0", proto_err - e0); end
    endtask

    task automatic test_start_in_run();
        int n, rc; logic ct, das; longint s;
        do_flush();
        for (int i = 1; i <= LEN; i++) begin push_a(8'(i)); push_b(8'd2); end
        s = model_sum();
        run_dot(3, n, rc, ct, das);
        vectors++; if (n != LEN + 1 || rc != LEN) begin miscompares++; $display("FAIL run_start_latency: got %0d reads %0d want %0d reads %0d", n, rc, LEN + 1, LEN); end
        vectors++; if (bus8.result !== 24'(s)) begin miscompares++; $display("FAIL run_start_result: got %0d want %0d", bus8.result, 24'(s)); end
        do_flush();
        for (int i = 1; i <= LEN; i++) begin push_a(8'(i)); push_b(8'(i)); end
        s = model_sum();
        run_dot(-1, n, rc, ct, das);
        vectors++; if (das !== 1'b0) begin miscompares++; $display("FAIL restart_done_drop: got %0b want 0", das); end
        vectors++; if (bus8.result !== 24'(s)) begin miscompares++; $display("FAIL restart_result: got %0d want %0d", bus8.result, 24'(s)); end
        vectors++; if (bus16.result !== 16'(s)) begin miscompares++; $display("FAIL restart_result16: got %0d want %0d", bus16.result, 16'(s)); end
    endtask

    task automatic test_reset_mid();
        int base, popped;
        do_flush();
        for (int i = 0; i < LEN; i++) begin push_a(8'($urandom_range(255))); push_b(8'($urandom_range(255))); end
        base = a_rp;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_flags: got done %0b busy %0b want 0 0", bus8.done, bus8.busy); end
        vectors++; if (bus8.result !== 24'd0) begin miscompares++; $display("FAIL midreset_result: got %0d want 0", bus8.result); end
        vectors++; if ({bus8.a_rden, bus8.b_rden} !== 2'b00) begin miscompares++; $display("FAIL midreset_rden: got %b want 00", {bus8.a_rden, bus8.b_rden}); end
        rst_n = 1'b1;
        popped = a_rp - base;
        repeat (4) @(negedge clk);
        vectors++; if (popped < 3 || popped > 4 || a_rp - base != popped) begin miscompares++; $display("FAIL midreset_pops: got %0d then %0d want 3..4 unchanged", popped, a_rp - base); end
        vectors++; if (bus8.a_empty !== 1'b0) begin miscompares++; $display("FAIL midreset_left: got empty %0b want 0", bus8.a_empty); end
    endtask

    task automatic test_uneven();
        int n, rc; logic ct, das; longint s;
        do_flush();
        for (int i = 0; i < LEN + 2; i++) push_a(8'($urandom_range(255)));
        for (int i = 0; i < LEN; i++) push_b(8'($urandom_range(255)));
        s = model_sum();
        run_dot(-1, n, rc, ct, das);
        vectors++; if (bus8.done !== 1'b1 || bus8.result !== 24'(s)) begin miscompares++; $display("FAIL uneven_result: got done %0b %0d want 1 %0d", bus8.done, bus8.result, 24'(s)); end
        vectors++; if (a_wp - a_rp != 2 || b_wp != b_rp) begin miscompares++; $display("FAIL uneven_left: got %0d/%0d want 2/0", a_wp - a_rp, b_wp - b_rp); end
        vectors++; if (bus8.a_empty !== 1'b0 || bus8.b_empty !== 1'b1) begin miscompares++; $display("FAIL uneven_empty: got %0b%0b want 01", bus8.a_empty, bus8.b_empty); end
    endtask

    task automatic test_random();
        int n, rc; logic ct, das; longint s; int xa, xb, e0;
        rnd_en = 1'b1;
        for (int it = 0; it < 12; it++) begin
            do_flush();
            xa = $urandom_range(3); xb = $urandom_range(3);
            for (int i = 0; i < LEN + xa; i++) push_a(8'($urandom_range(255)));
            for (int i = 0; i < LEN + xb; i++) push_b(8'($urandom_range(255)));
            s = model_sum(); e0 = proto_err;
            run_dot(-1, n, rc, ct, das);
            vectors++; if (bus8.result !== 24'(s) || bus16.result !== 16'(s)) begin miscompares++; $display("FAIL rand_result[%0d]: got %0d/%0d want %0d/%0d", it, bus8.result, bus16.result, 24'(s), 16'(s)); end
            vectors++; if (n < LEN + 1 || n > 200 || rc != LEN) begin miscompares++; $display("FAIL rand_timing[%0d]: got %0d edges %0d reads want >=%0d edges %0d reads", it, n, rc, LEN + 1, LEN); end
            vectors++; if (a_wp - a_rp != xa || b_wp - b_rp != xb) begin miscompares++; $display("FAIL rand_left[%0d]: got %0d/%0d want %0d/%0d", it, a_wp - a_rp, b_wp - b_rp, xa, xb); end
            vectors++; if (proto_err != e0) begin miscompares++; $display("FAIL rand_protocol[%0d]: got %0d violations want 0", it, proto_err - e0); end
        end
        rnd_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_start_in_run();
        test_reset_mid();
        test_uneven();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
